// File: rtl/ssc_pkg.sv
// Shared types and default constants for the side-street sensor conditioner.
package ssc_pkg;

    // Debounce FSM states for the loop detector.
    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        RISE_CHK = 2'd1,
        PRESENT  = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_t;

    // Default parameter values used by the top and the debouncer.
    localparam int SSC_DEBOUNCE_CYCLES = 4;
    localparam int SSC_CNT_W           = 4;
    localparam int SSC_STUCK_LIMIT     = 1000;

endpackage : ssc_pkg

// File: rtl/ssc_debounce.sv
// Two-flop synchroniser and debounce FSM for the side-street loop detector.
// Emits a one-cycle registered veh_evt when a new presence is accepted and
// exposes the debounced presence level.
module ssc_debounce
    import ssc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SSC_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_sensor,
    output logic veh_evt,
    output logic present
);

    localparam logic [7:0] RUN_TARGET = 8'(DEBOUNCE_CYCLES);

    logic       sync_q1;
    logic       sync_q2;
    deb_state_t state_reg;
    deb_state_t state_next;
    logic [7:0] run_reg;
    logic [7:0] run_next;
    logic       veh_evt_reg;
    logic       veh_evt_next;

    // Bring the asynchronous loop input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_sensor;
            sync_q2 <= sync_q1;
        end
    end

    // FSM state, run counter and event pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ABSENT;
            run_reg     <= 8'd0;
            veh_evt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            run_reg     <= run_next;
            veh_evt_reg <= veh_evt_next;
        end
    end

    // Next-state logic: a level change is accepted only after it has been
    // seen on DEBOUNCE_CYCLES consecutive samples; any contrary sample
    // abandons the check. A recovery from FALL_CHK is not a new vehicle.
    always_comb begin
        state_next   = state_reg;
        run_next     = run_reg;
        veh_evt_next = 1'b0;
        case (state_reg)
            ABSENT: begin
                if (sync_q2) begin
                    state_next = RISE_CHK;
                    run_next   = 8'd1;
                end
            end
            RISE_CHK: begin
                if (!sync_q2) begin
                    state_next = ABSENT;
                end else if (run_reg == RUN_TARGET) begin
                    state_next   = PRESENT;
                    veh_evt_next = 1'b1;
                end else begin
                    run_next = run_reg + 8'd1;
                end
            end
            PRESENT: begin
                if (!sync_q2) begin
                    state_next = FALL_CHK;
                    run_next   = 8'd1;
                end
            end
            FALL_CHK: begin
                if (sync_q2) begin
                    state_next = PRESENT;
                end else if (run_reg == RUN_TARGET) begin
                    state_next = ABSENT;
                end else begin
                    run_next = run_reg + 8'd1;
                end
            end
            default: begin
                state_next = ABSENT;
            end
        endcase
    end

    assign veh_evt = veh_evt_reg;
    // Debounced level: a vehicle is considered present until the fall is confirmed.
    assign present = (state_reg == PRESENT) || (state_reg == FALL_CHK);

endmodule : ssc_debounce

// File: rtl/side_sensor_conditioner.sv
// Side-street sensor conditioner: debounces the loop detector, counts waiting
// vehicles, and raises a registered request (Dss) to the light controller.
// Optional feature macro: SSC_STUCK_EN adds a stuck-sensor timer and the
// sensor_fault output; without it those are absent.
module side_sensor_conditioner
    import ssc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SSC_DEBOUNCE_CYCLES,
    parameter int CNT_W           = SSC_CNT_W,
    parameter int STUCK_LIMIT     = SSC_STUCK_LIMIT
) (
    input  logic             clk,
    input  logic             Dreset,
    input  logic             raw_sensor,
    input  logic             forSG,
    output logic             Dss,
    output logic [CNT_W-1:0] waiting
`ifdef SSC_STUCK_EN
    ,
    output logic             sensor_fault
`endif
);

    localparam logic [CNT_W-1:0] WAIT_MAX = '1;

    logic veh_evt;
    logic forSG_q;
    logic sg_rise;
    logic count_en;
    logic req_level;

`ifdef SSC_STUCK_EN
    localparam int TMR_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(STUCK_LIMIT);

    logic             present;
    logic [TMR_W-1:0] presence_tmr_reg;
`else
    logic             present_unused;
`endif

    ssc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (Dreset),
        .raw_sensor (raw_sensor),
        .veh_evt    (veh_evt),
`ifdef SSC_STUCK_EN
        .present    (present)
`else
        .present    (present_unused)
`endif
    );

    // Edge detect on the side-green lamp: the start of service empties the queue.
    always_ff @(posedge clk or negedge Dreset) begin
        if (!Dreset) begin
            forSG_q <= 1'b0;
        end else begin
            forSG_q <= forSG;
        end
    end

    assign sg_rise = forSG & ~forSG_q;

`ifdef SSC_STUCK_EN
    // Presence timer: counts cycles of debounced presence, saturating at the limit.
    always_ff @(posedge clk or negedge Dreset) begin
        if (!Dreset) begin
            presence_tmr_reg <= '0;
        end else if (!present) begin
            presence_tmr_reg <= '0;
        end else if (presence_tmr_reg != TMR_LIMIT) begin
            presence_tmr_reg <= presence_tmr_reg + 1'b1;
        end
    end

    // Stuck flag: set when the timer hits the limit, held until the loop
    // is seen absent again.
    always_ff @(posedge clk or negedge Dreset) begin
        if (!Dreset) begin
            sensor_fault <= 1'b0;
        end else if (!present) begin
            sensor_fault <= 1'b0;
        end else if (presence_tmr_reg == TMR_LIMIT) begin
            sensor_fault <= 1'b1;
        end
    end

    assign count_en  = veh_evt & ~forSG & ~sensor_fault;
    assign req_level = (waiting != '0) & ~sensor_fault;
`else
    assign count_en  = veh_evt & ~forSG;
    assign req_level = (waiting != '0);
`endif

    // Waiting-vehicle counter: cleared when service starts (clear wins),
    // otherwise counts accepted vehicles and saturates instead of wrapping.
    always_ff @(posedge clk or negedge Dreset) begin
        if (!Dreset) begin
            waiting <= '0;
        end else if (sg_rise) begin
            waiting <= '0;
        end else if (count_en && (waiting != WAIT_MAX)) begin
            waiting <= waiting + 1'b1;
        end
    end

    // Registered request to the controller, one cycle behind the counter.
    always_ff @(posedge clk or negedge Dreset) begin
        if (!Dreset) begin
            Dss <= 1'b0;
        end else begin
            Dss <= req_level;
        end
    end

endmodule : side_sensor_conditioner

// File: doc/side_sensor_conditioner.md
SIDE_SENSOR_CONDITIONER -- requirements
Module: side_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive synced cycles needed to accept a sensor level change (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 4, width of the waiting-vehicle counter.
REQ-003 SHALL have parameter STUCK_LIMIT, default 1000, cycles of continuous presence that declare the sensor stuck (used only under SSC_STUCK_EN).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port Dreset  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port raw_sensor  input  1  side-street loop detector; asynchronous to clk and may bounce.
REQ-007 SHALL have port forSG  input  1  side-green lamp from the downstream traffic light controller; 1 means side street is being served.
REQ-008 SHALL have port Dss  output  1  registered side-street request to the controller.
REQ-009 SHALL have port waiting  output  CNT_W  registered count of vehicles waiting.
REQ-010 SHALL have port sensor_fault  output  1  registered stuck-sensor flag; present only under SSC_STUCK_EN.

Function
REQ-011 SHALL synchronise raw_sensor through two flops (sync_q1, sync_q2) before any other use.
REQ-012 SHALL run a debounce FSM with states ABSENT, RISE_CHK, PRESENT, FALL_CHK and an 8-bit run counter.
REQ-013 ABSENT: sync_q2=1 -> RISE_CHK with run=1; otherwise hold.
REQ-014 RISE_CHK: sync_q2=0 -> ABSENT; sync_q2=1 and run=DEBOUNCE_CYCLES -> PRESENT and emit a one-cycle veh_evt; otherwise run+1.
REQ-015 PRESENT: sync_q2=0 -> FALL_CHK with run=1; otherwise hold.
REQ-016 FALL_CHK: sync_q2=1 -> PRESENT with no veh_evt; sync_q2=0 and run=DEBOUNCE_CYCLES -> ABSENT; otherwise run+1.
REQ-017 SHALL register forSG into forSG_q and form sg_rise = forSG & ~forSG_q.
REQ-018 On sg_rise, waiting SHALL clear to 0; clear takes priority over a simultaneous veh_evt.
REQ-019 While forSG=1, veh_evt SHALL be ignored, because passing vehicles are served.
REQ-020 Otherwise veh_evt SHALL increment waiting, saturating at 2^CNT_W-1 with no wrap.
REQ-021 Dss SHALL be registered as (waiting != 0), so it is one cycle after waiting changes.
REQ-022 Latency: raw_sensor held high from the edge where it is first sampled SHALL give Dss=1 exactly DEBOUNCE_CYCLES+4 edges later (8 for the default).
REQ-023 Dss SHALL stay 1 until waiting clears, independent of the sensor dropping.

Reset
REQ-024 Dreset=0 SHALL immediately force sync flops=0, FSM=ABSENT, run=0, forSG_q=0, waiting=0, Dss=0 and sensor_fault=0.
REQ-025 Reset asserted mid-debounce or mid-count SHALL discard all pending state; after release, operation restarts from ABSENT.

Configuration
REQ-026 With macro SSC_STUCK_EN defined, a presence timer SHALL count cycles in PRESENT; reaching STUCK_LIMIT sets sensor_fault.
REQ-027 sensor_fault SHALL be sticky until the FSM reaches ABSENT or reset; while it is 1, Dss is forced 0 and veh_evt is ignored.
REQ-028 Without SSC_STUCK_EN, the sensor_fault port, the presence timer and STUCK_LIMIT usage SHALL be absent; Dss follows REQ-021 only.

Structure
REQ-029 Shared package ssc_pkg SHALL hold the debounce state typedef (ABSENT, RISE_CHK, PRESENT, FALL_CHK) and the default constants for DEBOUNCE_CYCLES, CNT_W and STUCK_LIMIT.
REQ-030 The synchroniser plus debounce FSM SHALL be sub-module ssc_debounce, which outputs veh_evt and the present level.
REQ-031 Counter, request and fault logic SHALL live in the top module.

Verification
REQ-032 Reset, then raw_sensor=1 steady -> Dss=1 exactly 8 cycles after first sampling; waiting=1.
REQ-033 raw_sensor pulses high for 3 cycles (< DEBOUNCE_CYCLES) -> no veh_evt; waiting=0; Dss=0.
REQ-034 Five clean presence/absence cycles, each 10 high and 10 low, with forSG=0 -> waiting=5 and Dss=1; then forSG rises -> waiting=0 next cycle and Dss=0 one cycle later.
REQ-035 Twenty clean vehicles with CNT_W=4 -> waiting saturates at 15; veh_evt on the same cycle as sg_rise -> waiting=0.
REQ-036 Under SSC_STUCK_EN with STUCK_LIMIT=50, raw_sensor held high -> sensor_fault=1 and Dss=0; then raw_sensor=0 for DEBOUNCE_CYCLES+3 cycles -> sensor_fault=0.
REQ-037 Dreset asserted during RISE_CHK and while waiting=3 -> all outputs 0 immediately; after release, a fresh vehicle -> waiting=1.
